// File: rtl/bus_transfer_sequencer.sv
// Control sequencer for a single-bus register file: expands MOV/ADD/SUB/NOP
// commands into timed register, Y and Z enable steps with one bus driver per cycle.
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [IDX_W-1:0]    cmd_src_a,
  input  logic [IDX_W-1:0]    cmd_src_b,
  input  logic [IDX_W-1:0]    cmd_dst,
  output logic [NUM_REGS-1:0] r_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic                y_in,
  output logic                z_in,
  output logic                z_out,
  output logic                alu_sub,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    T1   = 2'b01,
    T2   = 2'b10,
    T3   = 2'b11
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [1:0]         op_r, op_nxt_s;
  logic [IDX_W-1:0]   src_a_r, src_a_nxt_s;
  logic [IDX_W-1:0]   src_b_r, src_b_nxt_s;
  logic [IDX_W-1:0]   dst_r, dst_nxt_s;
  logic               illegal_r, illegal_nxt_s;

  logic [NUM_REGS-1:0] r_out_nxt_s, r_in_nxt_s;
  logic                y_in_nxt_s, z_in_nxt_s, z_out_nxt_s, alu_sub_nxt_s;
  logic                done_nxt_s, err_nxt_s, ready_nxt_s, busy_nxt_s;

  function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} >= (IDX_W+1)'(NUM_REGS));
  endfunction

  function automatic logic cmd_illegal(input logic [1:0] op, input logic [IDX_W-1:0] a,
                                       input logic [IDX_W-1:0] b, input logic [IDX_W-1:0] d);
    logic bad;
    case (op)
      OP_MOV:         bad = idx_bad(a) || idx_bad(d);
      OP_ADD, OP_SUB: bad = idx_bad(a) || idx_bad(b) || idx_bad(d);
      default:        bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  // Next-state and command-latch logic; inputs only matter while idle.
  always_comb begin
    state_nxt_s   = state_r;
    op_nxt_s      = op_r;
    src_a_nxt_s   = src_a_r;
    src_b_nxt_s   = src_b_r;
    dst_nxt_s     = dst_r;
    illegal_nxt_s = illegal_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt_s   = T1;
          op_nxt_s      = cmd_op;
          src_a_nxt_s   = cmd_src_a;
          src_b_nxt_s   = cmd_src_b;
          dst_nxt_s     = cmd_dst;
          illegal_nxt_s = cmd_illegal(cmd_op, cmd_src_a, cmd_src_b, cmd_dst);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      T1: begin
        if (!illegal_r && (op_r == OP_ADD || op_r == OP_SUB)) begin
          state_nxt_s = T2;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      T2:      state_nxt_s = T3;
      T3:      state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode for the upcoming step, so the outputs themselves come from flops.
  always_comb begin
    r_out_nxt_s   = '0;
    r_in_nxt_s    = '0;
    y_in_nxt_s    = 1'b0;
    z_in_nxt_s    = 1'b0;
    z_out_nxt_s   = 1'b0;
    alu_sub_nxt_s = 1'b0;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    ready_nxt_s   = (state_nxt_s == IDLE);
    busy_nxt_s    = (state_nxt_s != IDLE);
    case (state_nxt_s)
      T1: begin
        if (illegal_nxt_s) begin
          done_nxt_s = 1'b1;
          err_nxt_s  = 1'b1;
        end else begin
          case (op_nxt_s)
            OP_MOV: begin
              r_out_nxt_s = one_hot(src_a_nxt_s);
              r_in_nxt_s  = one_hot(dst_nxt_s);
              done_nxt_s  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              r_out_nxt_s = one_hot(src_a_nxt_s);
              y_in_nxt_s  = 1'b1;
            end
            default: done_nxt_s = 1'b1;
          endcase
        end
      end
      T2: begin
        r_out_nxt_s   = one_hot(src_b_nxt_s);
        z_in_nxt_s    = 1'b1;
        alu_sub_nxt_s = (op_nxt_s == OP_SUB);
      end
      T3: begin
        z_out_nxt_s = 1'b1;
        r_in_nxt_s  = one_hot(dst_nxt_s);
        done_nxt_s  = 1'b1;
      end
      default: begin
        r_out_nxt_s = '0;
        r_in_nxt_s  = '0;
      end
    endcase
  end

  // State, latched command and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      op_r      <= 2'b00;
      src_a_r   <= '0;
      src_b_r   <= '0;
      dst_r     <= '0;
      illegal_r <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      r_out     <= '0;
      r_in      <= '0;
      y_in      <= 1'b0;
      z_in      <= 1'b0;
      z_out     <= 1'b0;
      alu_sub   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      op_r      <= op_nxt_s;
      src_a_r   <= src_a_nxt_s;
      src_b_r   <= src_b_nxt_s;
      dst_r     <= dst_nxt_s;
      illegal_r <= illegal_nxt_s;
      cmd_ready <= ready_nxt_s;
      busy      <= busy_nxt_s;
      r_out     <= r_out_nxt_s;
      r_in      <= r_in_nxt_s;
      y_in      <= y_in_nxt_s;
      z_in      <= z_in_nxt_s;
      z_out     <= z_out_nxt_s;
      alu_sub   <= alu_sub_nxt_s;
      done      <= done_nxt_s;
      err       <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: directed scenarios then random commands,
// compared cycle by cycle against a queue of expected control steps.
module tb_bus_transfer_sequencer;

  localparam int NUM_REGS = 6;
  localparam int IDX_W    = 3;
  localparam int N_RANDOM = 1000;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [IDX_W-1:0]    cmd_src_a, cmd_src_b, cmd_dst;
  logic [NUM_REGS-1:0] r_out, r_in;
  logic                y_in, z_in, z_out, alu_sub, busy, done, err;

  always #5 clk = ~clk;

  bus_transfer_sequencer #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .r_out(r_out), .r_in(r_in), .y_in(y_in), .z_in(z_in), .z_out(z_out),
    .alu_sub(alu_sub), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [NUM_REGS-1:0] r_out;
    logic [NUM_REGS-1:0] r_in;
    logic y_in, z_in, z_out, alu_sub, done, err;
  } step_t;

  step_t exp_q[$];
  step_t cur;
  bit    cur_busy;
  int    n_vec, n_err, n_acc, cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [NUM_REGS-1:0] bit_of(input int idx);
    return NUM_REGS'(1) << idx;
  endfunction

  function automatic bit bad(input int idx);
    return idx >= NUM_REGS;
  endfunction

  // Expand a command into the list of control steps it must produce.
  task automatic expand(input int op, input int a, input int b, input int d);
    step_t s;
    bit    illegal;
    illegal = (op == 1 && (bad(a) || bad(d))) || (op >= 2 && (bad(a) || bad(b) || bad(d)));
    s = '0;
    if (illegal) begin
      s.done = 1'b1; s.err = 1'b1; exp_q.push_back(s);
    end else if (op == 0) begin
      s.done = 1'b1; exp_q.push_back(s);
    end else if (op == 1) begin
      s.r_out = bit_of(a); s.r_in = bit_of(d); s.done = 1'b1; exp_q.push_back(s);
    end else begin
      s.r_out = bit_of(a); s.y_in = 1'b1; exp_q.push_back(s);
      s = '0;
      s.r_out = bit_of(b); s.z_in = 1'b1; s.alu_sub = (op == 3); exp_q.push_back(s);
      s = '0;
      s.z_out = 1'b1; s.r_in = bit_of(d); s.done = 1'b1; exp_q.push_back(s);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      exp_q.delete(); cur = '0; cur_busy = 1'b0;
    end else if (!cur_busy && cmd_valid) begin
      expand(int'(cmd_op), int'(cmd_src_a), int'(cmd_src_b), int'(cmd_dst));
      cur = exp_q.pop_front(); cur_busy = 1'b1; n_acc++;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front(); cur_busy = 1'b1;
    end else begin
      cur = '0; cur_busy = 1'b0;
    end
    @(negedge clk);
    cyc++;
    check_eq("ctl", 32'({cmd_ready, busy, done, err, y_in, z_in, z_out, alu_sub}),
             32'({!cur_busy, cur_busy, cur.done, cur.err, cur.y_in, cur.z_in, cur.z_out, cur.alu_sub}));
    check_eq("r_out", 32'(r_out), 32'(cur.r_out));
    check_eq("r_in", 32'(r_in), 32'(cur.r_in));
    check_eq("excl", 32'(($countones(r_out) + int'(z_out)) <= 1 && $countones(r_in) <= 1
                         && (int'(y_in) + int'(z_in) + int'(z_out)) <= 1), 32'd1);
  endtask

  task automatic drive(input logic v, input int op, input int a, input int b, input int d);
    cmd_valid = v;
    cmd_op    = 2'(op);
    cmd_src_a = IDX_W'(a);
    cmd_src_b = IDX_W'(b);
    cmd_dst   = IDX_W'(d);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int target;
    int budget;
    n_vec = 0; n_err = 0; n_acc = 0; cyc = 0;
    cur = '0; cur_busy = 1'b0;
    reset = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    run(2);
    reset = 1'b0;
    run(1);

    drive(1'b1, 1, 3, 0, 5); step(); drive(1'b0, 0, 0, 0, 0); run(2);
    drive(1'b1, 2, 1, 2, 5); step(); drive(1'b0, 0, 0, 0, 0); run(4);
    drive(1'b1, 3, 1, 2, 4); step(); drive(1'b0, 0, 0, 0, 0); run(4);
    drive(1'b1, 1, 6, 0, 0); step(); drive(1'b0, 0, 0, 0, 0); run(2);
    drive(1'b1, 2, 1, 7, 0); step(); drive(1'b0, 0, 0, 0, 0); run(2);

    // Back-to-back with cmd_valid held, then a pulse while busy.
    drive(1'b1, 1, 0, 0, 1); step();
    drive(1'b1, 2, 2, 3, 4); run(2);
    drive(1'b0, 0, 0, 0, 0); step();
    drive(1'b1, 0, 0, 0, 0); step();
    drive(1'b0, 0, 0, 0, 0); run(2);

    // Reset during T2 of SUB.
    drive(1'b1, 3, 2, 3, 5); step();
    drive(1'b0, 0, 0, 0, 0); step();
    reset = 1'b1; step();
    reset = 1'b0; run(2);

    target = n_acc + N_RANDOM;
    budget = 20000;
    while (n_acc < target && budget > 0) begin
      reset = ($urandom_range(0, 199) == 0);
      drive(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      step();
      budget--;
    end
    reset = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    run(4);
    check_eq("cmd_count", 32'(n_acc >= target), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
